// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, state encoding and width helper for the CNN layer engines
package cnn_pkg;

   localparam int DATA_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } pool_state_e;

   // Bits needed to index n locations (never less than one bit)
   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - window scan counters, read address and write-aligned output address
module pool_addr_gen
   import cnn_pkg::*;
#(
   parameter int IN_W   = 24,
   parameter int IN_H   = 24,
   parameter int NUM_CH = 6,
   parameter int RD_AW  = 12,
   parameter int WR_AW  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [RD_AW-1:0] rd_addr,
   output logic             last_out,
   output logic             dly_vld,
   output logic             dly_first,
   output logic             dly_last_tap,
   output logic             dly_last_out,
   output logic [WR_AW-1:0] dly_oaddr
);

   localparam int OUT_W = IN_W / 2;
   localparam int OUT_H = IN_H / 2;
   localparam int CH_W  = addr_w(NUM_CH);
   localparam int ROW_W = addr_w(OUT_H);
   localparam int COL_W = addr_w(OUT_W);

   logic [CH_W-1:0]  ch_q, ch_d;
   logic [ROW_W-1:0] orow_q, orow_d;
   logic [COL_W-1:0] ocol_q, ocol_d;
   logic [1:0]       tap_q, tap_d;

   logic             dly_vld_q, dly_vld_d;
   logic             dly_first_q, dly_first_d;
   logic             dly_last_tap_q, dly_last_tap_d;
   logic             dly_last_out_q, dly_last_out_d;
   logic [WR_AW-1:0] dly_oaddr_q, dly_oaddr_d;

   logic last_tap, last_col, last_row, last_ch;
   int   rd_addr_int;
   int   oaddr_int;

   assign last_tap = (tap_q == 2'd3);
   assign last_col = (ocol_q == COL_W'(OUT_W - 1));
   assign last_row = (orow_q == ROW_W'(OUT_H - 1));
   assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));
   assign last_out = last_tap & last_col & last_row & last_ch;

   // Tap address (r + tap[1], c + tap[0]) and output address from the live counters
   always_comb begin
      rd_addr_int = int'(ch_q) * (IN_H * IN_W)
                  + (2 * int'(orow_q) + int'(tap_q[1])) * IN_W
                  + 2 * int'(ocol_q) + int'(tap_q[0]);
      oaddr_int   = int'(ch_q) * (OUT_H * OUT_W) + int'(orow_q) * OUT_W + int'(ocol_q);
   end

   assign rd_addr = RD_AW'(rd_addr_int);

   // Counter advance: tap innermost, then ocol, orow, channel
   always_comb begin
      ch_d   = ch_q;
      orow_d = orow_q;
      ocol_d = ocol_q;
      tap_d  = tap_q;
      if (clr) begin
         ch_d   = '0;
         orow_d = '0;
         ocol_d = '0;
         tap_d  = '0;
      end else if (adv) begin
         tap_d = tap_q + 2'd1;
         if (last_tap) begin
            if (last_col) begin
               ocol_d = '0;
               if (last_row) begin
                  orow_d = '0;
                  ch_d   = last_ch ? '0 : ch_q + 1'b1;
               end else begin
                  orow_d = orow_q + 1'b1;
               end
            end else begin
               ocol_d = ocol_q + 1'b1;
            end
         end
      end
   end

   // Tag each issued read so its flags line up with the returning data
   always_comb begin
      dly_vld_d      = adv;
      dly_first_d    = adv & (tap_q == 2'd0);
      dly_last_tap_d = adv & last_tap;
      dly_last_out_d = adv & last_out;
      dly_oaddr_d    = WR_AW'(oaddr_int);
   end

   // Counter and delay registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q           <= '0;
         orow_q         <= '0;
         ocol_q         <= '0;
         tap_q          <= '0;
         dly_vld_q      <= 1'b0;
         dly_first_q    <= 1'b0;
         dly_last_tap_q <= 1'b0;
         dly_last_out_q <= 1'b0;
         dly_oaddr_q    <= '0;
      end else begin
         ch_q           <= ch_d;
         orow_q         <= orow_d;
         ocol_q         <= ocol_d;
         tap_q          <= tap_d;
         dly_vld_q      <= dly_vld_d;
         dly_first_q    <= dly_first_d;
         dly_last_tap_q <= dly_last_tap_d;
         dly_last_out_q <= dly_last_out_d;
         dly_oaddr_q    <= dly_oaddr_d;
      end
   end

   assign dly_vld      = dly_vld_q;
   assign dly_first    = dly_first_q;
   assign dly_last_tap = dly_last_tap_q;
   assign dly_last_out = dly_last_out_q;
   assign dly_oaddr    = dly_oaddr_q;

endmodule

// File: rtl/maxpool_engine.sv
// rtl/maxpool_engine.sv - 2x2 stride-2 max-pooling engine for one CNN layer
module maxpool_engine
   import cnn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int IN_W   = 24,
   parameter int IN_H   = 24,
   parameter int NUM_CH = 6,
   parameter int RD_AW  = addr_w(NUM_CH * IN_H * IN_W),
   parameter int WR_AW  = addr_w(NUM_CH * (IN_H / 2) * (IN_W / 2))
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              pool_done,
   output logic              rd_en,
   output logic [RD_AW-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [WR_AW-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   pool_state_e state_q, state_d;
   logic        start_q, start_d;

   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
   logic                     wr_en_q, wr_en_d;
   logic                     wr_last_q, wr_last_d;
   logic [WR_AW-1:0]         wr_addr_q, wr_addr_d;

   logic signed [DATA_W-1:0] rd_s;
   logic signed [DATA_W-1:0] tap_max;

   logic             ag_clr;
   logic             ag_last_out;
   logic             ag_dly_vld;
   logic             ag_dly_first;
   logic             ag_dly_last_tap;
   logic             ag_dly_last_out;
   logic [WR_AW-1:0] ag_dly_oaddr;

   assign ag_clr = (state_q == ST_IDLE);

   pool_addr_gen #(
      .IN_W   (IN_W),
      .IN_H   (IN_H),
      .NUM_CH (NUM_CH),
      .RD_AW  (RD_AW),
      .WR_AW  (WR_AW)
   ) u_addr_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (ag_clr),
      .adv          (rd_en),
      .rd_addr      (rd_addr),
      .last_out     (ag_last_out),
      .dly_vld      (ag_dly_vld),
      .dly_first    (ag_dly_first),
      .dly_last_tap (ag_dly_last_tap),
      .dly_last_out (ag_dly_last_out),
      .dly_oaddr    (ag_dly_oaddr)
   );

   // State and launch-edge registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   // Next state: launch on a rising start edge in IDLE, drain until the last write lands
   always_comb begin
      start_d = start;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start && !start_q) state_d = ST_RUN;
         ST_RUN:   if (ag_last_out) state_d = ST_DRAIN;
         ST_DRAIN: if (wr_en_q && wr_last_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      rd_en     = (state_q == ST_RUN);
      pool_done = (state_q == ST_DONE);
   end

   assign rd_s    = rd_data;
   assign tap_max = (rd_s > acc_q) ? rd_s : acc_q;

   // Running max over the four taps; the fourth tap produces the registered write
   always_comb begin
      acc_d     = acc_q;
      wr_en_d   = 1'b0;
      wr_last_d = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (ag_dly_vld) begin
         acc_d = ag_dly_first ? rd_s : tap_max;
         if (ag_dly_last_tap) begin
            wr_en_d   = 1'b1;
            wr_last_d = ag_dly_last_out;
            wr_addr_d = ag_dly_oaddr;
            wr_data_d = tap_max;
         end
      end
   end

   // Accumulator and write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_last_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         acc_q     <= acc_d;
         wr_en_q   <= wr_en_d;
         wr_last_q <= wr_last_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// tb/tb_maxpool_engine.sv - directed bench for maxpool_engine
module tb_maxpool_engine;

   logic clk;
   logic rst_n;
   logic start;
   logic start_b;
   logic seq_en;
   logic seq_start = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int n_done;
   int done_cyc;
   int n_bad_b = 0;
   int n_rd_b = 0;

   int rd_tab_a [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
   int exp_b    [8]  = '{6, 8, 16, 18, 31, 33, 41, 43};

   logic [15:0] mem_a [16];
   logic [15:0] mem_b [50];
   logic [15:0] mem_c [16];

   logic        busy_a, done_a, rd_en_a, wr_en_a;
   logic [7:0]  rd_addr_a;
   logic [3:0]  wr_addr_a;
   logic [15:0] rd_data_a = '0;
   logic [15:0] wr_data_a;

   logic        busy_b, done_b, rd_en_b, wr_en_b;
   logic [7:0]  rd_addr_b;
   logic [3:0]  wr_addr_b;
   logic [15:0] rd_data_b = '0;
   logic [15:0] wr_data_b;

   logic        busy_c, done_c, rd_en_c, wr_en_c;
   logic [7:0]  rd_addr_c;
   logic [3:0]  wr_addr_c;
   logic [15:0] rd_data_c = '0;
   logic [15:0] wr_data_c;

   maxpool_engine #(.DATA_W(16), .IN_W(4), .IN_H(4), .NUM_CH(1), .RD_AW(8), .WR_AW(4)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .pool_done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

   maxpool_engine #(.DATA_W(16), .IN_W(5), .IN_H(5), .NUM_CH(2), .RD_AW(8), .WR_AW(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .pool_done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

   maxpool_engine #(.DATA_W(16), .IN_W(4), .IN_H(4), .NUM_CH(1), .RD_AW(8), .WR_AW(4)) u_c (
      .clk(clk), .rst_n(rst_n), .start(seq_start), .busy(busy_c), .pool_done(done_c),
      .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
      .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous-read buffers, one cycle latency
   always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a[3:0]];
   always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[int'(rd_addr_b)];
   always @(posedge clk) if (rd_en_c) rd_data_c <= mem_c[rd_addr_c[3:0]];

   // sequencer stub: registered pool_done launches the second engine
   always @(posedge clk) seq_start <= seq_en & done_a;

   // odd-geometry read monitor: row 4 / col 4 of a channel must never be read
   always @(negedge clk) begin
      if (rd_en_b) begin
         n_rd_b++;
         if ((int'(rd_addr_b) % 25) / 5 == 4 || int'(rd_addr_b) % 5 == 4) n_bad_b++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one 4x4x1 run on u_a; caller is just after an edge with start low for a cycle
   task automatic run_a(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
      logic [15:0] ed [4];
      logic        we;
      ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3;
      start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         we = (k >= 6) && (k <= 18) && ((k - 6) % 4 == 0);
         check($sformatf("%s busy c%0d", tag, k), 32'(busy_a), 32'(k <= 18));
         check($sformatf("%s done c%0d", tag, k), 32'(done_a), 32'(k == 19));
         check($sformatf("%s rd_en c%0d", tag, k), 32'(rd_en_a), 32'(k <= 16));
         if (k <= 16) check($sformatf("%s rd_addr c%0d", tag, k), 32'(rd_addr_a), 32'(rd_tab_a[k-1]));
         check($sformatf("%s wr_en c%0d", tag, k), 32'(wr_en_a), 32'(we));
         if (we) begin
            check($sformatf("%s wr_addr c%0d", tag, k), 32'(wr_addr_a), 32'((k - 6) / 4));
            check($sformatf("%s wr_data c%0d", tag, k), 32'(wr_data_a), {16'h0, ed[(k-6)/4]});
         end
      end
   endtask

   initial begin
      logic we;
      rst_n = 1'b0; start = 1'b0; start_b = 1'b0; seq_en = 1'b0;
      for (int i = 0; i < 16; i++) begin mem_a[i] = 16'(i); mem_c[i] = 16'(i); end
      for (int i = 0; i < 50; i++) mem_b[i] = 16'(i);

      // reset state
      tick(); tick(); tick();
      check("rst busy", 32'(busy_a), 0);
      check("rst done", 32'(done_a), 0);
      check("rst rd_en", 32'(rd_en_a), 0);
      check("rst rd_addr", 32'(rd_addr_a), 0);
      check("rst wr_en", 32'(wr_en_a), 0);
      check("rst wr_addr", 32'(wr_addr_a), 0);
      check("rst wr_data", 32'(wr_data_a), 0);
      rst_n = 1'b1;
      tick();

      // single channel ramp
      run_a("ramp", 16'd5, 16'd7, 16'd13, 16'd15);

      // signed windows, including all-equal and most-negative values
      mem_a[0]  = -16'sd5;     mem_a[1]  = -16'sd2;     mem_a[4]  = -16'sd9;     mem_a[5]  = -16'sd3;
      mem_a[2]  = -16'sd7;     mem_a[3]  = -16'sd7;     mem_a[6]  = -16'sd7;     mem_a[7]  = -16'sd7;
      mem_a[8]  = -16'sd100;   mem_a[9]  = 16'h8000;    mem_a[12] = -16'sd1;     mem_a[13] = -16'sd50;
      mem_a[10] = 16'h8000;    mem_a[11] = 16'h8001;    mem_a[14] = 16'h8000;    mem_a[15] = 16'h8000;
      tick();
      run_a("signed", 16'hFFFE, 16'hFFF9, 16'hFFFF, 16'h8001);

      // odd dims, two channels
      start_b = 1'b1;
      for (int k = 1; k <= 37; k++) begin
         tick();
         if (k == 1) start_b = 1'b0;
         we = (k >= 6) && (k <= 34) && ((k - 6) % 4 == 0);
         check($sformatf("odd wr_en c%0d", k), 32'(wr_en_b), 32'(we));
         if (we) begin
            check($sformatf("odd wr_addr c%0d", k), 32'(wr_addr_b), 32'((k - 6) / 4));
            check($sformatf("odd wr_data c%0d", k), 32'(wr_data_b), 32'(exp_b[(k-6)/4]));
         end
         if (k == 17) check("odd ch1 first rd_addr", 32'(rd_addr_b), 25);
         check($sformatf("odd done c%0d", k), 32'(done_b), 32'(k == 35));
         check($sformatf("odd busy c%0d", k), 32'(busy_b), 32'(k <= 34));
      end
      check("odd bad reads", 32'(n_bad_b), 0);
      check("odd read count", 32'(n_rd_b), 32);

      // start held high: one run only
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
      start = 1'b1;
      n_done = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (done_a) n_done++;
      end
      check("held done count", 32'(n_done), 1);
      check("held idle", 32'(busy_a), 0);
      start = 1'b0;
      tick();
      start = 1'b1;
      n_done = 0; done_cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 5) start = 1'b0;
         if (k == 7) start = 1'b1;
         if (done_a) begin n_done++; done_cyc = k; end
      end
      check("relaunch done count", 32'(n_done), 1);
      check("relaunch done cycle", 32'(done_cyc), 19);
      check("relaunch idle", 32'(busy_a), 0);
      start = 1'b0;
      tick();

      // reset mid-run
      start = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy_a), 0);
      check("midrst done", 32'(done_a), 0);
      check("midrst rd_en", 32'(rd_en_a), 0);
      check("midrst rd_addr", 32'(rd_addr_a), 0);
      check("midrst wr_en", 32'(wr_en_a), 0);
      check("midrst wr_addr", 32'(wr_addr_a), 0);
      check("midrst wr_data", 32'(wr_data_a), 0);
      tick(); tick();
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (done_a || busy_a) n_done++;
      end
      check("midrst no activity", 32'(n_done), 0);
      run_a("rerun", 16'd5, 16'd7, 16'd13, 16'd15);

      // back-to-back through the sequencer stub
      seq_en = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         if (k == 19) check("seq a done", 32'(done_a), 1);
         if (k == 20) check("seq c rd_en early", 32'(rd_en_c), 0);
         if (k == 21) begin
            check("seq c rd_en", 32'(rd_en_c), 1);
            check("seq c rd_addr", 32'(rd_addr_c), 0);
         end
         if (k == 26) check("seq c first data", 32'(wr_data_c), 5);
         if (k == 38) check("seq c last data", 32'(wr_data_c), 15);
         if (k == 39) check("seq c done", 32'(done_c), 1);
      end
      seq_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/maxpool_engine.md
Name: maxpool_engine

Overview:
- 2x2, stride-2 max-pooling engine for one CNN layer.
- Launched by the layer sequencer's `start`; reports completion on `pool_done`, which the sequencer consumes as `pool1_done` or `pool2_done`.
- Reads the previous layer's feature maps from a synchronous-read buffer and writes the pooled maps to the next layer's buffer.
- One instance per pooling layer, differing only in parameters.

Parameters:
- DATA_W, 16, signed pixel width (two's complement)
- IN_W, 24, input map width in pixels
- IN_H, 24, input map height in pixels
- NUM_CH, 6, channels (maps) processed per run
- RD_AW, 12, read address width; must hold NUM_CH*IN_H*IN_W
- WR_AW, 10, write address width; must hold NUM_CH*(IN_H/2)*(IN_W/2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch request from layer sequencer (level; rising edge qualifies)
- busy  out  1  high while a run is in progress
- pool_done  out  1  one-cycle completion pulse
- rd_en  out  1  input buffer read strobe
- rd_addr  out  RD_AW  input buffer address
- rd_data  in  DATA_W  input pixel; valid the cycle after rd_en (1-cycle read latency)
- wr_en  out  1  output buffer write strobe
- wr_addr  out  WR_AW  output buffer address
- wr_data  out  DATA_W  pooled pixel

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, counters 0, start_q 0.
- Derived constants:
  - OUT_W = IN_W/2, OUT_H = IN_H/2 (floor). Odd trailing row/column is never read.
  - N_OUT = NUM_CH*OUT_H*OUT_W.
- Launch:
  - start_q registers start.
  - A run launches only in IDLE, and only when start=1 and start_q=0 (rising edge).
  - start held high after a run does not relaunch.
  - Edges outside IDLE are ignored.
- States:
  - IDLE: wait for qualified edge, then go to RUN.
  - RUN: issue 4 reads per output pixel.
  - DRAIN: wait for the last write.
  - DONE: one cycle, then IDLE.
- Scan order: channel (outer), orow, ocol (inner).
- Taps for output (ch, orow, ocol), with r=2*orow, c=2*ocol, issued in consecutive cycles:
  - tap0 (r,c), tap1 (r,c+1), tap2 (r+1,c), tap3 (r+1,c+1).
  - rd_addr = ch*IN_H*IN_W + row*IN_W + col.
- Timing, with cycle 0 = cycle in which the qualified edge is sampled:
  - tap0 of output n issued in cycle 1+4n. rd_en is continuously high through RUN (4*N_OUT cycles).
  - Accumulator: loaded with tap0 data, then acc = signed max(acc, rd_data) for taps 1-3.
  - Output n is written in cycle 6+4n (registered): wr_en=1, wr_addr = ch*OUT_H*OUT_W + orow*OUT_W + ocol, wr_data = max of the 4 taps.
  - Writes of consecutive outputs are 4 cycles apart. The pipeline overlaps, so the next tap0 issues while the previous output's taps are still landing.
  - Last write in cycle 4*N_OUT+2. pool_done high in cycle 4*N_OUT+3 only.
  - busy high in cycles 1 .. 4*N_OUT+2; low in the pool_done cycle.
- Compare rules:
  - Signed compare over full DATA_W, no saturation.
  - Ties keep the earlier tap's value (bitwise identical either way).
- Wrap-around:
  - ocol wraps to 0 and increments orow.
  - orow wraps and increments ch.
  - ch wrap at NUM_CH-1 ends RUN (enter DRAIN).
- Reset mid-run: immediate return to IDLE; strobes drop, no pool_done. A new run restarts from output 0.
- rd_data is ignored in cycles where no read is outstanding.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W default.
  - State encoding constants for IDLE/RUN/DRAIN/DONE.
  - clog2-based address-width helper, used to size RD_AW/WR_AW per layer.
- Sub-module pool_addr_gen:
  - Owns the ch/orow/ocol/tap counters and their wrap logic.
  - Produces rd_addr, a last-tap flag, a last-output flag and the output address, delayed to align with the write.
- maxpool_engine keeps the FSM, the accumulator and the output registers.

Test Plan:
- Single channel, small map: IN_W=4, IN_H=4, NUM_CH=1, input = 0..15 row-major; pulse start at cycle 0 -> writes in cycles 6, 10, 14, 18 with (addr, data) = (0,5), (1,7), (2,13), (3,15); pool_done in cycle 19 only; busy cycles 1-18.
- Signed: same geometry, all inputs negative, window 0 = {-5,-2,-9,-3} -> wr_data = -2 (0xFFFE); all-equal window -7 -> -7.
- Odd dims and channels: IN_W=5, IN_H=5, NUM_CH=2 -> 8 writes to addrs 0-7; no rd_addr ever has row 4 or col 4 of a channel; ch1 reads start at address 25.
- Start held: start held high for 100 cycles -> exactly one run and one pool_done. A second rising edge after IDLE launches a second run; an edge during busy does nothing.
- Reset mid-run: assert rst_n=0 in cycle 9 -> all outputs 0 immediately, no pool_done. Relaunch -> full correct run from address 0.
- Back-to-back sequencing: pool_done wired into a sequencer stub that launches a second engine instance -> second engine's first rd_en appears 2 cycles after pool_done (sequencer register plus edge sample).
